// File: rtl/post_history_pkg.sv
// Shared constants for the SBC6120 POST display: device select, extended IOT function codes,
// the millisecond divisor helper and the read-response payload type.
package post_history_pkg;

  localparam int unsigned IOT_W = 12;

  localparam logic [5:0] POST_SEL_DEFAULT = 6'o44;

  localparam logic [2:0] POST_PRS = 3'd0;
  localparam logic [2:0] POST_PWC = 3'd1;
  localparam logic [2:0] POST_PRC = 3'd2;
  localparam logic [2:0] POST_PSK = 3'd3;
  localparam logic [2:0] POST_PCL = 3'd4;
  localparam logic [2:0] POST_PHD = 3'd5;

  // What a selected read IOT puts back on the bus in the same cycle.
  typedef struct packed {
    logic             oe;
    logic             c0;
    logic             c1;
    logic             skip;
    logic [IOT_W-1:0] data;
  } iot_rsp_t;

  // Clocks per millisecond tick.
  function automatic int unsigned ms_divisor(input int unsigned clk_hz);
    return clk_hz / 32'd1000;
  endfunction

endpackage

// File: rtl/post_iot_if.sv
// HD6120 IOT bus strobes and control returns (the tristate dx bus is carried as a plain port).
interface post_iot_if;
  import post_history_pkg::*;

  logic [0:IOT_W-1] ax;
  logic             iord;
  logic             iowr;
  logic             ioclr;
  logic             ioc0;
  logic             ioc1;
  logic             ioskip;

  modport master (output ax, iord, iowr, ioclr, input ioc0, ioc1, ioskip);
  modport slave  (input ax, iord, iowr, ioclr, output ioc0, ioc1, ioskip);

endinterface

// File: rtl/post_history_fifo.sv
// History FIFO for post_history: overwrite-oldest on full, flush has priority over push/pop.
module post_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop_c;

  assign full     = (count == CW'(DEPTH));
  assign do_pop_c = pop && (count != '0);
  assign dout     = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // On a full push the write slot is the oldest entry, so the read pointer steps past it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop_c || (push && full)) rd_ptr <= rd_ptr + PW'(1);
      if (push && !do_pop_c && !full) count <= count + CW'(1);
      else if (!push && do_pop_c)     count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/post_history.sv
// SBC6120 POST display: legacy 644n code latch plus extended IOTs, boot-code history FIFO
// and a millisecond display-hold so short-lived codes are still visible.
module post_history
  import post_history_pkg::*;
#(
  parameter logic [5:0]  SELECT       = POST_SEL_DEFAULT,
  parameter int unsigned WIDTH        = 6,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned SYSTEM_CLOCK = 50000000,
  parameter int unsigned HOLD_MS      = 250
) (
  input  logic             clock,
  input  logic             reset_n,
  post_iot_if.slave        bus,
  inout  wire  [0:IOT_W-1] dx,
  output logic [WIDTH-1:0] leds,
  output logic             ovf
);

  localparam int unsigned DIV = ms_divisor(SYSTEM_CLOCK);
  localparam int unsigned PSW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW  = $clog2(DEPTH) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Registered state and next-state values.
  logic [0:0]       st, st_n;
  logic [IOT_W-1:0] hold_cnt, hold_n;
  logic [IOT_W-1:0] hold_reg, hold_reg_n;
  logic [WIDTH-1:0] leds_n;
  logic [WIDTH-1:0] pending, pending_n;
  logic             pend_v, pend_v_n;
  logic             ovf_n;
  logic [PSW-1:0]   presc, presc_n;

  // Decode and datapath nets.
  logic [5:0]       dev_c;
  logic [2:0]       fn_c;
  logic             leg_wr_c, ext_sel_c, ext_rd_c, ext_wr_c;
  logic             pwc_c, pcl_c, phd_c;
  logic             accept_c, pop_c, flush_c, tick_c;
  logic [WIDTH-1:0] code_c;
  logic [WIDTH-1:0] fifo_dout;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  iot_rsp_t         rsp_c;
  logic             unused_opcode_c;

  assign dev_c           = bus.ax[3:8];
  assign fn_c            = bus.ax[9:11];
  assign unused_opcode_c = ^bus.ax[0:2];

  assign leg_wr_c  = bus.iowr && (dev_c == SELECT);
  assign ext_sel_c = (dev_c == 6'(SELECT + 6'd1));
  assign ext_rd_c  = bus.iord && ext_sel_c;
  assign ext_wr_c  = bus.iowr && ext_sel_c;
  assign pwc_c     = ext_wr_c && (fn_c == POST_PWC);
  assign pcl_c     = ext_wr_c && (fn_c == POST_PCL);
  assign phd_c     = ext_wr_c && (fn_c == POST_PHD);

  // A code arriving with CAF is thrown away entirely.
  assign accept_c = (leg_wr_c || pwc_c) && !bus.ioclr;
  assign code_c   = leg_wr_c ? WIDTH'(bus.ax[9:11]) : dx[IOT_W-WIDTH:IOT_W-1];
  assign pop_c    = ext_rd_c && (fn_c == POST_PRC) && (fifo_count != '0);
  assign flush_c  = bus.ioclr || pcl_c;
  assign tick_c   = (presc == PSW'(DIV - 1));

  post_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (accept_c),
    .pop     (pop_c),
    .flush   (flush_c),
    .din     (code_c),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  // Same-cycle read response; AC is left alone when PRC finds the history empty.
  always_comb begin
    rsp_c = '0;
    if (ext_rd_c) begin
      case (fn_c)
        POST_PRS: begin
          rsp_c.oe   = 1'b1;
          rsp_c.c0   = 1'b1;
          rsp_c.c1   = 1'b1;
          rsp_c.data = {ovf, pend_v, (hold_cnt != '0), 3'b000, 6'(fifo_count)};
        end
        POST_PRC: begin
          if (fifo_count != '0) begin
            rsp_c.oe   = 1'b1;
            rsp_c.c0   = 1'b1;
            rsp_c.c1   = 1'b1;
            rsp_c.skip = 1'b1;
            rsp_c.data = IOT_W'(fifo_dout);
          end
        end
        POST_PSK: rsp_c.skip = (fifo_count != '0);
        default:  rsp_c = '0;
      endcase
    end
  end

  assign bus.ioc0   = rsp_c.c0;
  assign bus.ioc1   = rsp_c.c1;
  assign bus.ioskip = rsp_c.skip;
  assign dx         = rsp_c.oe ? rsp_c.data : {IOT_W{1'bz}};

  // Hold FSM next state: expiry is resolved first, then a same-cycle code lands on the result.
  always_comb begin
    st_n       = st;
    hold_n     = hold_cnt;
    hold_reg_n = hold_reg;
    leds_n     = leds;
    pending_n  = pending;
    pend_v_n   = pend_v;
    ovf_n      = ovf;
    presc_n    = tick_c ? '0 : presc + PSW'(1);

    if (flush_c)                                   ovf_n = 1'b0;
    else if (accept_c && fifo_full && !pop_c)      ovf_n = 1'b1;

    if (phd_c)     hold_reg_n = dx;
    if (bus.ioclr) pend_v_n   = 1'b0;

    case (st)
      ST_HOLD: begin
        if (tick_c) begin
          hold_n = hold_cnt - IOT_W'(1);
          if (hold_cnt == IOT_W'(1)) begin
            st_n = ST_IDLE;
            if (pend_v_n) begin
              leds_n   = pending;
              pend_v_n = 1'b0;
              hold_n   = hold_reg;
              if (hold_reg != '0) st_n = ST_HOLD;
            end
          end
        end
      end
      default: st_n = st;
    endcase

    if (accept_c) begin
      if (st_n == ST_IDLE) begin
        leds_n = code_c;
        hold_n = hold_reg;
        if (hold_reg != '0) st_n = ST_HOLD;
      end else begin
        pending_n = code_c;
        pend_v_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st       <= ST_IDLE;
      hold_cnt <= '0;
      hold_reg <= IOT_W'(HOLD_MS);
      leds     <= '1;
      pending  <= '0;
      pend_v   <= 1'b0;
      ovf      <= 1'b0;
      presc    <= '0;
    end else begin
      st       <= st_n;
      hold_cnt <= hold_n;
      hold_reg <= hold_reg_n;
      leds     <= leds_n;
      pending  <= pending_n;
      pend_v   <= pend_v_n;
      ovf      <= ovf_n;
      presc    <= presc_n;
    end
  end

endmodule
